tc_seq: RTL and testbench

TC_SEQ -- requirements
Module: tc_seq

---
 rtl/tc_seq_pkg.sv | 18 +
 rtl/tc_seq_if.sv | 27 ++
 rtl/tc_seq_tc16c.sv | 19 +
 rtl/tc_seq.sv | 120 ++++++++++++
 tb/tb_tc_seq.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/tc_seq_pkg.sv
// Shared constants and state encoding for the multi-word true/complement sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tc_seq_pkg;

   // Datapath word width in bits
   localparam int WW = 16;

   // Default maximum operand length in words
   localparam int NW_DEF = 4;

   // Sequencer states
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/tc_seq_if.sv
// Command/data bundle between a word source and the tc_seq sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; the source presents one word per dv cycle.
interface tc_seq_if #(
   parameter int LW = 2
);
   logic                       stb;
   logic                       cmp;
   logic [LW-1:0]              len;
   logic                       dv;
   logic [tc_seq_pkg::WW-1:0]  d;
   logic [tc_seq_pkg::WW-1:0]  y;
   logic                       yv;
   logic                       busy;
   logic                       done;
   logic                       ovf;

   modport master (
      output stb, cmp, len, dv, d,
      input  y, yv, busy, done, ovf
   );

   modport slave (
      input  stb, cmp, len, dv, d,
      output y, yv, busy, done, ovf
   );
endinterface

// File: rtl/tc_seq_tc16c.sv
// Combinational true/complement adder: {co,y} = (cmp ? ~d : d) + ci.
// Latency: 0 cycles, no state.
// Backpressure: none.
module tc16c
   import tc_seq_pkg::*;
(
   input  logic [WW-1:0] d,
   input  logic          cmp,
   input  logic          ci,
   output logic [WW-1:0] y,
   output logic          co
);

   logic [WW-1:0] opnd;

   assign opnd    = cmp ? ~d : d;
   assign {co, y} = {1'b0, opnd} + {{WW{1'b0}}, ci};

endmodule

// File: rtl/tc_seq.sv
// Multi-word two's-complement negate / pass-through, LS word first, carry rippled across words.
// Latency: 1 cycle from accepted word to registered y/yv; done rides with the last yv.
// Backpressure: none; dv=0 stalls the sequence with all state held.
module tc_seq
   import tc_seq_pkg::*;
#(
   parameter int NW = NW_DEF,
   parameter int LW = $clog2(NW)
)(
   input  logic     clk,
   input  logic     rst,
   tc_seq_if.slave  bus
);

   state_t        state_q, state_d;
   logic [LW-1:0] cnt_q, cnt_d;
   logic [LW-1:0] len_q, len_d;
   logic          cmp_q, cmp_d;
   logic          carry_q, carry_d;
   logic [WW-1:0] y_q, y_d;
   logic          yv_q, yv_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          ovf_q, ovf_d;

   logic [WW-1:0] sum;
   logic          co;
   logic          last;

   tc16c u_tc16c (
      .d   (bus.d),
      .cmp (cmp_q),
      .ci  (carry_q),
      .y   (sum),
      .co  (co)
   );

   // Final word of the operand; the NW-1 bound keeps the counter from ever wrapping
   assign last = (cnt_q == len_q) || (int'(cnt_q) == NW - 1);

   // Next-state and next-output logic: IDLE waits for stb, RUN consumes one word per dv
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      cmp_d   = cmp_q;
      carry_d = carry_q;
      y_d     = y_q;
      yv_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            // dv is deliberately ignored here, including on the stb edge itself
            if (bus.stb) begin
               state_d = RUN;
               cmp_d   = bus.cmp;
               len_d   = bus.len;
               cnt_d   = '0;
               carry_d = bus.cmp;
               ovf_d   = 1'b0;
               busy_d  = 1'b1;
            end
         end
         RUN: begin
            // busy stays high through the done cycle, falling on the edge after it
            busy_d = 1'b1;
            if (bus.dv) begin
               y_d     = sum;
               carry_d = co;
               yv_d    = 1'b1;
               if (last) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                  // negating the most-negative value yields itself
                  ovf_d   = cmp_q & bus.d[WW-1] & sum[WW-1];
               end else begin
                  cnt_d = cnt_q + LW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers, cleared asynchronously by rst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         cmp_q   <= 1'b0;
         carry_q <= 1'b0;
         y_q     <= '0;
         yv_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         cmp_q   <= cmp_d;
         carry_q <= carry_d;
         y_q     <= y_d;
         yv_q    <= yv_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.y    = y_q;
   assign bus.yv   = yv_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_tc_seq.sv
// Directed bench for tc_seq: cycle table of inputs/expected outputs plus a reset-abort sequence.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: dv gaps exercised in the table.
module tb_tc_seq;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   tc_seq_if #(.LW(2)) bus ();

   tc_seq #(.NW(4), .LW(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        stb;
      logic        cmp;
      logic [1:0]  len;
      logic        dv;
      logic [15:0] d;
      logic [15:0] ey;
      logic        eyv;
      logic        ebusy;
      logic        edone;
      logic        eovf;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(input logic stb, input logic cmp, input logic [1:0] len,
                               input logic dv, input logic [15:0] d, input logic [15:0] ey,
                               input logic eyv, input logic ebusy, input logic edone,
                               input logic eovf);
      vec_t v;
      v.stb = stb; v.cmp = cmp; v.len = len; v.dv = dv; v.d = d;
      v.ey = ey; v.eyv = eyv; v.ebusy = ebusy; v.edone = edone; v.eovf = eovf;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", tag, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [15:0] ey, input logic eyv,
                          input logic ebusy, input logic edone, input logic eovf);
      chk({tag, ".y"},    bus.y,         ey);
      chk({tag, ".yv"},   16'(bus.yv),   16'(eyv));
      chk({tag, ".busy"}, 16'(bus.busy), 16'(ebusy));
      chk({tag, ".done"}, 16'(bus.done), 16'(edone));
      chk({tag, ".ovf"},  16'(bus.ovf),  16'(eovf));
   endtask

   task automatic drive(input logic stb, input logic cmp, input logic [1:0] len,
                        input logic dv, input logic [15:0] d);
      bus.stb = stb; bus.cmp = cmp; bus.len = len; bus.dv = dv; bus.d = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //                stb cmp len dv  d         y        yv busy done ovf
      // single-word negate of 1
      vecs.push_back(mk(1, 1, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'h0001, 16'hFFFF, 1, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'hFFFF, 0, 0, 0, 0));
      // four-word negate, stb and dv together (dv ignored on that edge)
      vecs.push_back(mk(1, 1, 3, 1, 16'h5555, 16'hFFFF, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0000, 1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0000, 1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'h0001, 16'hFFFF, 1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 16'hFFFF, 1, 1, 1, 0));
      // back-to-back stb in the done cycle; carry was 0, must reload to 1
      vecs.push_back(mk(1, 1, 1, 0, 16'h0000, 16'hFFFF, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0000, 1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'h8000, 16'h8000, 1, 1, 1, 1));
      // ovf held while idle, cleared by the next stb
      vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h8000, 0, 0, 0, 1));
      vecs.push_back(mk(1, 0, 2, 0, 16'h0000, 16'h8000, 0, 1, 0, 0));
      // pass-through with dv gaps; stb during run is ignored
      vecs.push_back(mk(0, 0, 0, 1, 16'h1234, 16'h1234, 1, 1, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 16'hFFFF, 16'h1234, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 16'hFFFF, 16'h1234, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'hABCD, 16'hABCD, 1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'h0F0F, 16'h0F0F, 1, 1, 1, 0));
      // dv while idle produces nothing
      vecs.push_back(mk(0, 0, 0, 1, 16'h7777, 16'h0F0F, 0, 0, 0, 0));

      rst = 1'b1;
      drive(0, 0, 0, 0, 16'h0000);
      #1;
      chk_all("reset", 16'h0000, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].stb, vecs[i].cmp, vecs[i].len, vecs[i].dv, vecs[i].d);
         tick();
         chk_all($sformatf("vec%0d", i), vecs[i].ey, vecs[i].eyv, vecs[i].ebusy,
                 vecs[i].edone, vecs[i].eovf);
      end

      // reset after two of four words abandons the operation
      drive(1, 1, 3, 0, 16'h0000);
      tick();
      chk_all("abort.stb", 16'h0F0F, 0, 1, 0, 0);
      drive(0, 0, 0, 1, 16'h0001);
      tick();
      chk_all("abort.w0", 16'hFFFF, 1, 1, 0, 0);
      drive(0, 0, 0, 1, 16'h0000);
      tick();
      chk_all("abort.w1", 16'hFFFF, 1, 1, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      chk_all("abort.async", 16'h0000, 0, 0, 0, 0);
      tick();
      chk_all("abort.held", 16'h0000, 0, 0, 0, 0);
      rst = 1'b0;
      drive(0, 0, 0, 1, 16'h1234);
      tick();
      chk_all("abort.nostb", 16'h0000, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 16'h0000);
      tick();
      chk_all("fresh.stb", 16'h0000, 0, 1, 0, 0);
      drive(0, 0, 0, 1, 16'h0000);
      tick();
      chk_all("fresh.w0", 16'h0000, 1, 1, 1, 0);
      drive(0, 0, 0, 0, 16'h0000);
      tick();
      chk_all("fresh.idle", 16'h0000, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
